// File: rtl/uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_assembler
// Purpose  : Packs a stream of UART bytes into fixed-size frames and presents
//            them to a downstream coprocessor with a valid/ready handshake.
//            A shadow buffer keeps collecting while a frame is presented, so
//            one complete frame can wait behind the presented one; bytes that
//            arrive beyond that are dropped and flagged as overflow. A partial
//            frame left idle for TIMEOUT_CYCLES clocks is discarded.
// Ports    : clk, rst (async, active-high)
//            rx_byte[DBITS], rx_byte_valid     - byte stream from the UART
//            flush                             - discard the partial frame
//            frame_ready                       - downstream accepts a frame
//            frame_data[FRAME_BYTES*DBITS]     - byte k at [k*DBITS +: DBITS]
//            frame_valid                       - frame_data holds a frame
//            byte_count[8]                     - bytes in the partial frame
//            overflow                          - sticky dropped-byte flag
//            timeout_pulse                     - one-cycle partial discard
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_assembler #(
    parameter int FRAME_BYTES    = 16,
    parameter int DBITS          = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DBITS-1:0]             rx_byte,
    input  logic                         rx_byte_valid,
    input  logic                         flush,
    input  logic                         frame_ready,
    output logic [FRAME_BYTES*DBITS-1:0] frame_data,
    output logic                         frame_valid,
    output logic [7:0]                   byte_count,
    output logic                         overflow,
    output logic                         timeout_pulse
);

    localparam int              c_FW        = FRAME_BYTES * DBITS;
    localparam int              c_TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic            c_TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [7:0]      c_LAST_SLOT = 8'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,   // nothing presented, filling the shadow buffer
        S_PRESENT = 2'd1,   // frame presented, shadow buffer still filling
        S_DRAIN   = 2'd2    // frame presented and shadow buffer full
    } state_t;

    state_t          r_state;
    logic [c_FW-1:0] r_shadow;
    logic [c_FW-1:0] w_shadow_next;
    logic [c_TW-1:0] r_timer;
    logic            w_handshake;
    logic            w_accept;
    logic            w_last;
    logic            w_timeout;

    always_comb begin
        w_handshake = frame_valid & frame_ready;
        // A byte is taken only when there is room and no flush wipes it out.
        w_accept    = rx_byte_valid & ~flush & (r_state != S_DRAIN);
        w_last      = w_accept & (byte_count == c_LAST_SLOT);
        // An arriving byte restarts the idle count, so it wins over timeout.
        w_timeout   = c_TO_EN & ~flush & ~w_accept & (byte_count != 8'd0)
                      & (r_timer == c_TO_LAST);

        // Shadow buffer with the incoming byte merged into its slot; used both
        // to update the shadow and to load frame_data on the completing edge.
        w_shadow_next = r_shadow;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (byte_count == 8'(k)) begin
                w_shadow_next[k*DBITS +: DBITS] = rx_byte;
            end
        end
    end

    // Shadow storage is deliberately not reset: a slot is only ever read after
    // it has been written, so its power-up contents never become visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow <= w_shadow_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_COLLECT;
            frame_data    <= '0;
            frame_valid   <= 1'b0;
            byte_count    <= 8'd0;
            overflow      <= 1'b0;
            timeout_pulse <= 1'b0;
            r_timer       <= '0;
        end else begin
            timeout_pulse <= w_timeout;

            // Partial-frame bookkeeping.
            if (flush) begin
                byte_count <= 8'd0;
            end else if (w_accept) begin
                byte_count <= w_last ? 8'd0 : byte_count + 8'd1;
            end else if (w_timeout) begin
                byte_count <= 8'd0;
            end

            // Idle counter only runs while a partial frame is pending.
            if (flush || w_accept || w_timeout || (byte_count == 8'd0)) begin
                r_timer <= '0;
            end else if (c_TO_EN) begin
                r_timer <= r_timer + 1'b1;
            end

            // A strobe while both buffers are full has nowhere to go.
            if (rx_byte_valid && !flush && (r_state == S_DRAIN)) begin
                overflow <= 1'b1;
            end

            case (r_state)
                S_COLLECT: begin
                    if (w_last) begin
                        frame_data  <= w_shadow_next;
                        frame_valid <= 1'b1;
                        r_state     <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (w_last && w_handshake) begin
                        // Presented frame leaves as the next one completes:
                        // hand over directly and keep frame_valid asserted.
                        frame_data <= w_shadow_next;
                    end else if (w_last) begin
                        r_state <= S_DRAIN;
                    end else if (w_handshake) begin
                        frame_valid <= 1'b0;
                        r_state     <= S_COLLECT;
                    end
                end
                S_DRAIN: begin
                    if (w_handshake) begin
                        frame_data <= r_shadow;
                        r_state    <= S_PRESENT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_assembler
// Purpose  : Self-checking bench for uart_frame_assembler (16 x 8-bit frames,
//            100-cycle timeout). Completed frames are queued as they are sent
//            and compared against frame_data at each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_assembler;

    localparam int FB = 16;
    localparam int DB = 8;
    localparam int TO = 100;

    logic              clk;
    logic              rst;
    logic [DB-1:0]     rx_byte;
    logic              rx_byte_valid;
    logic              flush;
    logic              frame_ready;
    logic [FB*DB-1:0]  frame_data;
    logic              frame_valid;
    logic [7:0]        byte_count;
    logic              overflow;
    logic              timeout_pulse;

    int total = 0;
    int bad   = 0;

    logic [FB*DB-1:0] exp_q[$];
    logic [FB*DB-1:0] m_frame;
    int               m_cnt = 0;

    uart_frame_assembler #(
        .FRAME_BYTES   (FB),
        .DBITS         (DB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .flush        (flush),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .byte_count   (byte_count),
        .overflow     (overflow),
        .timeout_pulse(timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: on the cycle before a handshake edge, the presented
    // frame must match the oldest queued frame; while a frame is held without
    // a handshake, frame_data must not change.
    logic             prev_valid = 1'b0;
    logic             prev_hs    = 1'b0;
    logic [FB*DB-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst && prev_valid && !prev_hs && frame_valid) begin
            total++;
            if (frame_data !== prev_data) begin
                bad++;
                $display("FAIL hold_stable: got %h required %h", frame_data, prev_data);
            end
        end
        if (!rst && frame_valid && frame_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_unexpected: got %h required no frame", frame_data);
            end else begin
                logic [FB*DB-1:0] e;
                e = exp_q.pop_front();
                if (frame_data !== e) begin
                    bad++;
                    $display("FAIL frame_data: got %h required %h", frame_data, e);
                end
            end
        end
        prev_valid = frame_valid & ~rst;
        prev_hs    = frame_valid & frame_ready;
        prev_data  = frame_data;
    end

    // Stimulus helpers; all start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input bit drop);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        if (!drop) begin
            m_frame[m_cnt*8 +: 8] = b;
            m_cnt++;
            if (m_cnt == FB) begin
                exp_q.push_back(m_frame);
                m_cnt = 0;
            end
        end
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_byte = '0; rx_byte_valid = 1'b0; flush = 1'b0; frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({frame_data, frame_valid, byte_count, overflow, timeout_pulse} !== '0) begin
            bad++;
            $display("FAIL reset_state: got data=%h v=%b cnt=%0d ovf=%b to=%b required all 0",
                     frame_data, frame_valid, byte_count, overflow, timeout_pulse);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic;
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(8'(i), 1'b0);
        total++;
        if (byte_count !== 8'd15 || frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_count15: got cnt=%0d v=%b required cnt=15 v=0", byte_count, frame_valid);
        end
        send(8'h0F, 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h00 || frame_data[127:120] !== 8'h0F
            || byte_count !== 8'd0) begin
            bad++;
            $display("FAIL basic_frame: got v=%b b0=%h b15=%h cnt=%0d required v=1 b0=00 b15=0f cnt=0",
                     frame_valid, frame_data[7:0], frame_data[127:120], byte_count);
        end
        idle(1);
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_valid_drop: got %b required 0", frame_valid);
        end
    endtask

    task automatic test_coincident;
        frame_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 15; i++) send(8'(8'h50 + i), 1'b0);
        frame_ready = 1'b1;
        send(8'h5F, 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h50 || frame_data[127:120] !== 8'h5F
            || overflow !== 1'b0) begin
            bad++;
            $display("FAIL coincident_load: got v=%b b0=%h b15=%h ovf=%b required v=1 b0=50 b15=5f ovf=0",
                     frame_valid, frame_data[7:0], frame_data[127:120], overflow);
        end
        idle(1);
        total++;
        if (frame_valid !== 1'b0) begin
            bad++;
            $display("FAIL coincident_drop: got %b required 0", frame_valid);
        end
    endtask

    task automatic test_timeout;
        bit early;
        frame_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'(8'h60 + i), 1'b0);
        early = 1'b0;
        for (int i = 1; i < TO; i++) begin
            idle(1);
            if (timeout_pulse !== 1'b0 || byte_count !== 8'd5) early = 1'b1;
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL timeout_early: got pulse or count change before idle cycle %0d required none", TO);
        end
        idle(1);
        total++;
        if (timeout_pulse !== 1'b1 || byte_count !== 8'd0) begin
            bad++;
            $display("FAIL timeout_fire: got pulse=%b cnt=%0d required pulse=1 cnt=0", timeout_pulse, byte_count);
        end
        m_cnt = 0;
        idle(1);
        total++;
        if (timeout_pulse !== 1'b0) begin
            bad++;
            $display("FAIL timeout_one_cycle: got %b required 0", timeout_pulse);
        end
        for (int i = 0; i < 16; i++) send(8'(8'h70 + i), 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h70) begin
            bad++;
            $display("FAIL timeout_next_frame: got v=%b b0=%h required v=1 b0=70", frame_valid, frame_data[7:0]);
        end
        idle(2);
    endtask

    task automatic test_flush;
        frame_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'(8'h80 + i), 1'b0);
        flush = 1'b1; rx_byte = 8'h83; rx_byte_valid = 1'b1;
        m_cnt = 0;
        @(posedge clk); #1;
        flush = 1'b0; rx_byte_valid = 1'b0;
        total++;
        if (byte_count !== 8'd0) begin
            bad++;
            $display("FAIL flush_count: got %0d required 0", byte_count);
        end
        for (int i = 0; i < 16; i++) send(8'(8'h90 + i), 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h90 || frame_data[127:120] !== 8'h9F) begin
            bad++;
            $display("FAIL flush_next_frame: got v=%b b0=%h b15=%h required v=1 b0=90 b15=9f",
                     frame_valid, frame_data[7:0], frame_data[127:120]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) send(8'(8'h10 + i), 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h10 || byte_count !== 8'd0
            || overflow !== 1'b0) begin
            bad++;
            $display("FAIL drain_hold: got v=%b b0=%h cnt=%0d ovf=%b required v=1 b0=10 cnt=0 ovf=0",
                     frame_valid, frame_data[7:0], byte_count, overflow);
        end
        send(8'hEE, 1'b1);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL drain_overflow: got %b required 1", overflow);
        end
        frame_ready = 1'b1;
        idle(1);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'h20 || frame_data[127:120] !== 8'h2F) begin
            bad++;
            $display("FAIL drain_second: got v=%b b0=%h b15=%h required v=1 b0=20 b15=2f",
                     frame_valid, frame_data[7:0], frame_data[127:120]);
        end
        idle(1);
        total++;
        if (frame_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL drain_end: got v=%b ovf=%b required v=0 ovf=1", frame_valid, overflow);
        end
    endtask

    task automatic test_reset_mid;
        frame_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'(8'hB0 + i), 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if ({frame_data, frame_valid, byte_count, overflow, timeout_pulse} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got data=%h v=%b cnt=%0d ovf=%b to=%b required all 0",
                     frame_data, frame_valid, byte_count, overflow, timeout_pulse);
        end
        m_cnt = 0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        frame_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'hA0 + i), 1'b0);
        total++;
        if (frame_valid !== 1'b1 || frame_data[7:0] !== 8'hA0 || frame_data[127:120] !== 8'hAF) begin
            bad++;
            $display("FAIL reset_fresh_frame: got v=%b b0=%h b15=%h required v=1 b0=a0 b15=af",
                     frame_valid, frame_data[7:0], frame_data[127:120]);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coincident();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d frames outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
